// File: rtl/golden_delivery_pkg.sv
// golden_delivery_pkg: shared state encoding and default timeout for the delivery controller
package golden_delivery_pkg;
    typedef enum logic [2:0] {
        IDLE,
        WAIT_CUSTOMS,
        WAIT_TRANSIT,
        RELEASED,
        DONE,
        FAULT
    } state_e;
    localparam int TIMEOUT_DEFAULT = 16;
endpackage

// File: rtl/golden_delivery_timer.sv
// golden_delivery_timer: per-state wait counter flagging the last allowed cycle
module golden_delivery_timer #(
    parameter int TIMEOUT_CYCLES = golden_delivery_pkg::TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam logic [7:0] LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
    assign cnt_d = clr ? 8'd0 : en ? cnt_q + 8'd1 : cnt_q;
    assign expired = cnt_q == LAST;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 8'd0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/golden_delivery_ctrl.sv
// golden_delivery_ctrl: shipment FSM gating release on customs/transit and confirming arrival
module golden_delivery_ctrl
    import golden_delivery_pkg::*;
#(
    parameter int ID_W           = 4,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEFAULT,
    parameter int CNT_W          = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [ID_W-1:0]  req_id,
    input  logic             customs_cleared,
    input  logic             transit_ready,
    input  logic             arrived_on_truck,
    input  logic             fault_clr,
    output logic             shipment_released,
    output logic             delivery_confirmed,
    output logic [ID_W-1:0]  delivery_id,
    output logic             fault,
    output logic [CNT_W-1:0] delivered_count
);
    state_e state_q, state_d;
    logic [ID_W-1:0] id_q, id_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic expired, waiting;

    assign waiting = state_q inside {WAIT_CUSTOMS, WAIT_TRANSIT, RELEASED};

    golden_delivery_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
        .clk(clk),
        .rst(rst),
        .clr(state_d != state_q),
        .en(waiting),
        .expired(expired)
    );

    // Progress conditions are tested before the timeout so they win on the last cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:         state_d = req_valid ? WAIT_CUSTOMS : IDLE;
            WAIT_CUSTOMS: state_d = customs_cleared ? WAIT_TRANSIT : expired ? FAULT : WAIT_CUSTOMS;
            WAIT_TRANSIT: state_d = (customs_cleared && transit_ready) ? RELEASED :
                                    !customs_cleared ? WAIT_CUSTOMS : expired ? FAULT : WAIT_TRANSIT;
            RELEASED:     state_d = (customs_cleared && arrived_on_truck) ? DONE :
                                    (!customs_cleared || expired) ? FAULT : RELEASED;
            DONE:         state_d = IDLE;
            FAULT:        state_d = fault_clr ? IDLE : FAULT;
            default:      state_d = IDLE;
        endcase
    end

    assign id_d  = (state_q == IDLE && req_valid) ? req_id : id_q;
    assign cnt_d = (state_d == DONE) ? cnt_q + 1'b1 : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            id_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
        end
    end

    assign req_ready          = state_q == IDLE;
    assign shipment_released  = state_q == RELEASED;
    assign delivery_confirmed = state_q == DONE;
    assign fault              = state_q == FAULT;
    assign delivery_id        = id_q;
    assign delivered_count    = cnt_q;
endmodule
